// File: rtl/median_pkg.sv
// rtl/median_pkg.sv - shared types and helpers for the median/rank order-statistic filter
// Contents: state_t (IDLE, LOAD, SORT, DONE), cnt_w() counter width helper,
//           sort_cycles() SORT-phase cycle count S(N, r).
package median_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SORT = 2'd2,
      DONE = 2'd3
   } state_t;

   // Width of counters that must hold values 0..n.
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

   // Each pass p scans the N-p elements still in the array, and the pass that
   // extracts the rank-r element is pass N-r-1.
   function automatic int sort_cycles(input int n, input int r);
      int s;
      s = 0;
      for (int p = 0; p <= n - r - 1; p++) begin
         s += n - p;
      end
      return s;
   endfunction

endpackage

// File: rtl/median_cmp.sv
// rtl/median_cmp.sv - combinational unsigned compare-select
// Ports: a_i, b_i   operands (WIDTH, unsigned)
//        max_o      larger operand (a_i on a tie)
//        min_o      smaller operand
//        ge_o       a_i >= b_i
module median_cmp #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] max_o,
   output logic [WIDTH-1:0] min_o,
   output logic             ge_o
);

   assign ge_o  = (a_i >= b_i);
   assign max_o = ge_o ? a_i : b_i;
   assign min_o = ge_o ? b_i : a_i;

endmodule

// File: rtl/median_rank_filter.sv
// rtl/median_rank_filter.sv - serial rank-r order-statistic filter over N-sample frames
// Ports: CLK   clock, rising edge
//        RST   synchronous active-high reset
//        DI    sample in, taken while DSI is high during a frame
//        DSI   frame strobe, high for N sample cycles
//        RANK  requested order statistic (0 = min), only with MEDIAN_RANK_EN
//        DO    result, held until the next DSO
//        DSO   one-cycle result-valid pulse
//        BUSY  high while a frame is being loaded or sorted
// Build option: MEDIAN_RANK_EN adds the RANK port; otherwise the rank is fixed at the median.
module median_rank_filter
   import median_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int N     = 9
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [WIDTH-1:0]     DI,
   input  logic                 DSI,
`ifdef MEDIAN_RANK_EN
   input  logic [$clog2(N)-1:0] RANK,
`endif
   output logic [WIDTH-1:0]     DO,
   output logic                 DSO,
   output logic                 BUSY
);

   localparam int            CW  = cnt_w(N);
   localparam logic [CW-1:0] NM1 = CW'(N - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] r_q [N];
   logic [WIDTH-1:0] r_d [N];
   logic [WIDTH-1:0] m_q, m_d;
   logic [CW-1:0]    idx_q, idx_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CW-1:0]    pass_q, pass_d;
   logic [CW-1:0]    elem_q, elem_d;
   logic [CW-1:0]    last_q, last_d;
   logic [WIDTH-1:0] do_q, do_d;
   logic             dso_q, dso_d;
   logic             busy_q, busy_d;
   logic             dsi_q;

   logic             dsi_rise;
   logic [CW-1:0]    rank_eff;
   logic [CW-1:0]    last_pass;
   logic [WIDTH-1:0] cur;
   logic [WIDTH-1:0] cmp_max;
   logic [WIDTH-1:0] cmp_min_unused;
   logic             cmp_ge;
   logic             first;
   logic             take;
   logic [WIDTH-1:0] max_now;
   logic [CW-1:0]    idx_now;
   logic             pass_end;

   assign dsi_rise = DSI & ~dsi_q;

`ifdef MEDIAN_RANK_EN
   logic [CW-1:0] rank_w;
   assign rank_w   = CW'(RANK);
   assign rank_eff = (rank_w > NM1) ? NM1 : rank_w;
`else
   assign rank_eff = CW'((N - 1) / 2);
`endif

   // The frame is finished once the pass extracting the rank-r element ends;
   // store that pass index instead of r itself.
   assign last_pass = NM1 - rank_eff;

   assign cur = r_q[elem_q];

   median_cmp #(
      .WIDTH(WIDTH)
   ) u_cmp (
      .a_i  (cur),
      .b_i  (m_q),
      .max_o(cmp_max),
      .min_o(cmp_min_unused),
      .ge_o (cmp_ge)
   );

   // First element of a pass seeds the running max regardless of stale M.
   assign first    = (elem_q == '0);
   assign take     = first | cmp_ge;
   assign max_now  = first ? cur : cmp_max;
   assign idx_now  = take ? elem_q : idx_q;
   assign pass_end = (elem_q == (NM1 - pass_q));

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      m_d     = m_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      pass_d  = pass_q;
      elem_d  = elem_q;
      last_d  = last_q;
      do_d    = do_q;
      dso_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (dsi_rise) begin
               r_d[0]  = DI;
               cnt_d   = CW'(1);
               last_d  = last_pass;
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (DSI) begin
               r_d[cnt_q] = DI;
               if (cnt_q == NM1) begin
                  cnt_d   = '0;
                  pass_d  = '0;
                  elem_d  = '0;
                  state_d = SORT;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else begin
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         SORT: begin
            if (dsi_rise) begin
               // A fresh frame preempts the one being sorted.
               r_d[0]  = DI;
               cnt_d   = CW'(1);
               pass_d  = '0;
               elem_d  = '0;
               last_d  = last_pass;
               state_d = LOAD;
            end else begin
               m_d   = max_now;
               idx_d = idx_now;
               if (pass_end) begin
                  if (pass_q == last_q) begin
                     state_d = DONE;
                  end else begin
                     // Remove the max by moving the last live element into its slot.
                     r_d[idx_now] = cur;
                     pass_d       = pass_q + CW'(1);
                     elem_d       = '0;
                  end
               end else begin
                  elem_d = elem_q + CW'(1);
               end
            end
         end
         DONE: begin
            do_d    = m_q;
            dso_d   = 1'b1;
            pass_d  = '0;
            elem_d  = '0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK) begin
      dsi_q <= DSI;
      if (RST) begin
         state_q <= IDLE;
         r_q     <= '{default: '0};
         m_q     <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         pass_q  <= '0;
         elem_q  <= '0;
         last_q  <= '0;
         do_q    <= '0;
         dso_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         m_q     <= m_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         pass_q  <= pass_d;
         elem_q  <= elem_d;
         last_q  <= last_d;
         do_q    <= do_d;
         dso_q   <= dso_d;
         busy_q  <= busy_d;
      end
   end

   assign DO   = do_q;
   assign DSO  = dso_q;
   assign BUSY = busy_q;

endmodule

// File: tb/tb_median_rank_filter.sv
// tb/tb_median_rank_filter.sv - directed self-checking bench for median_rank_filter
// Covers the 8-bit N=9 instance and a 12-bit N=3 instance; MEDIAN_RANK_EN adds rank tests.
module tb_median_rank_filter;
   import median_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  di;
   logic        dsi;
   logic [7:0]  dout;
   logic        dso;
   logic        busy;
   logic [11:0] di3;
   logic        dsi3;
   logic [11:0] dout3;
   logic        dso3;
   logic        busy3;
`ifdef MEDIAN_RANK_EN
   logic [3:0]  rank;
   logic [1:0]  rank3;
`endif

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  frame [9];

   always #5 clk = ~clk;

   median_rank_filter #(.WIDTH(8), .N(9)) u_dut (
      .CLK (clk),
      .RST (rst),
      .DI  (di),
      .DSI (dsi),
`ifdef MEDIAN_RANK_EN
      .RANK(rank),
`endif
      .DO  (dout),
      .DSO (dso),
      .BUSY(busy)
   );

   median_rank_filter #(.WIDTH(12), .N(3)) u_dut3 (
      .CLK (clk),
      .RST (rst),
      .DI  (di3),
      .DSI (dsi3),
`ifdef MEDIAN_RANK_EN
      .RANK(rank3),
`endif
      .DO  (dout3),
      .DSO (dso3),
      .BUSY(busy3)
   );

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic send_frame(input int cnt);
      for (int i = 0; i < cnt; i++) begin
         @(negedge clk);
         dsi = 1'b1;
         di  = frame[i];
      end
      @(negedge clk);
      dsi = 1'b0;
      di  = 8'd0;
   endtask

   task automatic wait_dso(input string tag, input int exp_lat, input int exp_do);
      int lat;
      bit seen;
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 400) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (dso) seen = 1'b1;
      end
      check({tag, " dso seen"}, int'(seen), 1);
      check({tag, " latency"}, lat, exp_lat);
      check({tag, " do"}, int'(dout), exp_do);
      check({tag, " busy at dso"}, int'(busy), 0);
      @(negedge clk);
      check({tag, " dso pulse"}, int'(dso), 0);
      check({tag, " do held"}, int'(dout), exp_do);
   endtask

   task automatic idle_watch(input string tag, input int cycles);
      bit hit;
      hit = 1'b0;
      repeat (cycles) begin
         @(negedge clk);
         if (dso) hit = 1'b1;
      end
      check(tag, int'(hit), 0);
   endtask

   initial begin
      int lat3;
      rst  = 1'b1;
      dsi  = 1'b0;
      di   = 8'd0;
      dsi3 = 1'b0;
      di3  = 12'd0;
`ifdef MEDIAN_RANK_EN
      rank  = 4'd4;
      rank3 = 2'd1;
`endif
      repeat (3) @(negedge clk);
      check("reset do", int'(dout), 0);
      check("reset dso", int'(dso), 0);
      check("reset busy", int'(busy), 0);
      check("reset do3", int'(dout3), 0);
      check("reset busy3", int'(busy3), 0);
      rst = 1'b0;

      check("pkg S(9,4)", sort_cycles(9, 4), 35);
      check("pkg S(9,0)", sort_cycles(9, 0), 45);
      check("pkg S(9,8)", sort_cycles(9, 8), 9);
      check("pkg S(3,1)", sort_cycles(3, 1), 5);

      // Median of a permutation of 1..9.
      frame = '{8'd5, 8'd1, 8'd9, 8'd3, 8'd7, 8'd2, 8'd8, 8'd6, 8'd4};
      send_frame(9);
      check("busy in sort", int'(busy), 1);
      wait_dso("median", sort_cycles(9, 4) + 1, 5);
      check("busy after", int'(busy), 0);

`ifdef MEDIAN_RANK_EN
      rank = 4'd0;
      send_frame(9);
      wait_dso("rank0", sort_cycles(9, 0) + 1, 1);
      rank = 4'd8;
      send_frame(9);
      wait_dso("rank8", sort_cycles(9, 8) + 1, 9);
      rank = 4'd12;
      send_frame(9);
      wait_dso("rank12 clamp", sort_cycles(9, 8) + 1, 9);
      rank = 4'd4;
`endif

      // Duplicates: sorted 0,0,3,3,3,7,7,7,7.
      frame = '{8'd3, 8'd3, 8'd3, 8'd0, 8'd0, 8'd7, 8'd7, 8'd7, 8'd7};
      send_frame(9);
      wait_dso("dups", sort_cycles(9, 4) + 1, 3);

      // Short frame: DSI drops after five samples.
      send_frame(5);
      idle_watch("short no dso", 60);
      check("short busy", int'(busy), 0);
      check("short do kept", int'(dout), 3);
      frame = '{default: 8'hAA};
      send_frame(9);
      wait_dso("after short", sort_cycles(9, 4) + 1, 170);

      // Abort: new rising edge on the 10th SORT cycle of the first frame.
      frame = '{8'd5, 8'd1, 8'd9, 8'd3, 8'd7, 8'd2, 8'd8, 8'd6, 8'd4};
      send_frame(9);
      idle_watch("abort window", 8);
      frame = '{8'd20, 8'd40, 8'd60, 8'd80, 8'd100, 8'd120, 8'd140, 8'd160, 8'd180};
      send_frame(9);
      wait_dso("abort second", sort_cycles(9, 4) + 1, 100);

      // Reset in the middle of LOAD.
      frame = '{8'd5, 8'd1, 8'd9, 8'd3, 8'd7, 8'd2, 8'd8, 8'd6, 8'd4};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         dsi = 1'b1;
         di  = frame[i];
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst load do", int'(dout), 0);
      check("rst load dso", int'(dso), 0);
      check("rst load busy", int'(busy), 0);
      rst = 1'b0;
      dsi = 1'b0;
      idle_watch("rst load no dso", 20);

      send_frame(9);
      wait_dso("post rst", sort_cycles(9, 4) + 1, 5);

      // Reset in the middle of SORT.
      send_frame(9);
      repeat (5) @(negedge clk);
      check("busy mid sort", int'(busy), 1);
      rst = 1'b1;
      @(negedge clk);
      check("rst sort do", int'(dout), 0);
      check("rst sort dso", int'(dso), 0);
      check("rst sort busy", int'(busy), 0);
      rst = 1'b0;
      idle_watch("rst sort no dso", 50);

      // 12-bit, N=3 instance.
      @(negedge clk);
      dsi3 = 1'b1;
      di3  = 12'd4095;
      @(negedge clk);
      di3  = 12'd0;
      @(negedge clk);
      di3  = 12'd2048;
      @(negedge clk);
      dsi3 = 1'b0;
      di3  = 12'd0;
      lat3 = 0;
      while (!dso3 && lat3 < 50) begin
         @(posedge clk);
         lat3++;
         @(negedge clk);
      end
      check("n3 dso seen", int'(dso3), 1);
      check("n3 latency", lat3, sort_cycles(3, 1) + 1);
      check("n3 do", int'(dout3), 2048);
      check("n3 busy at dso", int'(busy3), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
